// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Also hosts the saturating increment used by the stall-cycle counter.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO           = 5'd0;
    localparam int         MD_LATENCY_DEFAULT = 32;

    // Hold at all-ones instead of wrapping so long debug runs never read back small.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute hazard inputs and pipeline enable outputs of the controller.
// The master side drives the pipeline status; the slave side is the controller.
interface pipe_hazard_ctrl_if;

    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        id_md_start;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        ex_redirect;

    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_md_start,
               ex_mem_read, ex_rt, ex_redirect,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_md_start,
               ex_mem_read, ex_rt, ex_redirect,
        output pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Combinational load-use comparator: does the ID instruction read the register a
// load in ID/EX is about to write? Kept standalone so forwarding compares can reuse it.
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       load_use
);

    logic [4:0] src_reg [2];
    logic       src_use [2];
    logic [1:0] src_hit;

    assign src_reg[0] = id_rs;
    assign src_reg[1] = id_rt;
    assign src_use[0] = id_use_rs;
    assign src_use[1] = id_use_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] == ex_rt);
        end
    endgenerate

    // $zero is never really written, so a load targeting it cannot create a hazard.
    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) && (|src_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID enables, IF/ID flush, ID/EX bubble,
// mult/div wait state and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MD_LATENCY - 1);

    ctrl_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      stall_reg, stall_next;

    logic load_use;
    logic pc_write_c;
    logic ifid_write_c;
    logic ifid_flush_c;
    logic idex_bubble_c;
    logic md_busy_c;

    hazard_cmp u_hazard_cmp (
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .id_use_rs   (bus.id_use_rs),
        .id_use_rt   (bus.id_use_rt),
        .ex_mem_read (bus.ex_mem_read),
        .ex_rt       (bus.ex_rt),
        .load_use    (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
            stall_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            stall_reg <= stall_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        pc_write_c    = 1'b1;
        ifid_write_c  = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        md_busy_c     = 1'b0;

        case (state_reg)
            RUN: begin
                if (bus.ex_redirect) begin
                    // The ID instruction is squashed, so its hazards no longer matter.
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (load_use) begin
                    pc_write_c    = 1'b0;
                    ifid_write_c  = 1'b0;
                    idex_bubble_c = 1'b1;
                end else if (bus.id_md_start) begin
                    state_next = MD_WAIT;
                    cnt_next   = CNT_RELOAD;
                end
            end
            MD_WAIT: begin
                pc_write_c    = 1'b0;
                ifid_write_c  = 1'b0;
                idex_bubble_c = 1'b1;
                md_busy_c     = 1'b1;
                if (bus.ex_redirect) begin
                    // Take the redirect target now; the mult/div wait keeps running.
                    pc_write_c   = 1'b1;
                    ifid_flush_c = 1'b1;
                end
                if (cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase

        if (rst) begin
            state_next    = RUN;
            cnt_next      = '0;
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            md_busy_c     = 1'b0;
        end
    end

    assign stall_next = pc_write_c ? stall_reg : sat_inc(stall_reg);

    assign bus.pc_write     = pc_write_c;
    assign bus.ifid_write   = ifid_write_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.idex_bubble  = idex_bubble_c;
    assign bus.md_busy      = md_busy_c;
    assign bus.stall_cycles = stall_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MD_LATENCY=4: load-use, $zero, mult/div
// wait, redirect priority, combined hazards and reset in the middle of a wait.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    logic [31:0] exp_stall;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .MD_LATENCY (4),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_idle();
        bus.id_rs       = 5'd0;
        bus.id_rt       = 5'd0;
        bus.id_use_rs   = 1'b0;
        bus.id_use_rt   = 1'b0;
        bus.id_md_start = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rt       = 5'd0;
        bus.ex_redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_stall    = 32'd0;
        rst          = 1'b1;
        set_idle();

        // Reset: forced outputs while rst is high.
        #1;
        check("rst_pc_write",    {31'd0, bus.pc_write},    32'd0);
        check("rst_ifid_write",  {31'd0, bus.ifid_write},  32'd0);
        check("rst_ifid_flush",  {31'd0, bus.ifid_flush},  32'd1);
        check("rst_idex_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        check("rst_md_busy",     {31'd0, bus.md_busy},     32'd0);
        tick();
        check("rst_stall_cycles", bus.stall_cycles, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_pc_write",    {31'd0, bus.pc_write},    32'd1);
        check("idle_idex_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        tick();

        // Load to $5, ID reads rs=$5: one stall cycle.
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5; bus.id_use_rs = 1'b1;
        #1;
        check("lu_pc_write",    {31'd0, bus.pc_write},    32'd0);
        check("lu_ifid_write",  {31'd0, bus.ifid_write},  32'd0);
        check("lu_idex_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        check("lu_ifid_flush",  {31'd0, bus.ifid_flush},  32'd0);
        tick();
        exp_stall = 32'd1;
        bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0;
        #1;
        check("lu_after_pc_write",    {31'd0, bus.pc_write},    32'd1);
        check("lu_after_idex_bubble", {31'd0, bus.idex_bubble}, 32'd0);
        check("lu_stall_cycles",      bus.stall_cycles,         exp_stall);
        tick();

        // Load to $zero with ID reading $zero: no stall.
        set_idle();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_use_rs = 1'b1;
        #1;
        check("zero_pc_write", {31'd0, bus.pc_write}, 32'd1);
        tick();
        check("zero_stall_cycles", bus.stall_cycles, exp_stall);

        // Rt match only counts when the instruction reads rt.
        set_idle();
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd7;
        #1;
        check("rt_unused_pc_write", {31'd0, bus.pc_write}, 32'd1);
        bus.id_use_rt = 1'b1;
        #1;
        check("rt_used_pc_write", {31'd0, bus.pc_write}, 32'd0);
        tick();
        exp_stall = 32'd2;
        set_idle();
        #1;
        check("rt_stall_cycles", bus.stall_cycles, exp_stall);

        // Mult/div issue: advance this cycle, then 4 cycles of MD_WAIT.
        bus.id_md_start = 1'b1;
        #1;
        check("md_issue_pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("md_issue_busy",     {31'd0, bus.md_busy},  32'd0);
        tick();
        bus.id_md_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("md_wait%0d_busy", i),     {31'd0, bus.md_busy},     32'd1);
            check($sformatf("md_wait%0d_pc_write", i), {31'd0, bus.pc_write},    32'd0);
            check($sformatf("md_wait%0d_bubble", i),   {31'd0, bus.idex_bubble}, 32'd1);
            tick();
        end
        exp_stall = 32'd6;
        #1;
        check("md_done_busy",     {31'd0, bus.md_busy},  32'd0);
        check("md_done_pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("md_stall_cycles",  bus.stall_cycles,      exp_stall);
        tick();

        // Redirect together with load-use: flush wins, no stall.
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9; bus.id_use_rs = 1'b1;
        bus.ex_redirect = 1'b1; bus.id_md_start = 1'b1;
        #1;
        check("redir_pc_write",    {31'd0, bus.pc_write},    32'd1);
        check("redir_ifid_flush",  {31'd0, bus.ifid_flush},  32'd1);
        check("redir_idex_bubble", {31'd0, bus.idex_bubble}, 32'd1);
        tick();
        set_idle();
        #1;
        check("redir_no_md_busy", {31'd0, bus.md_busy}, 32'd0);
        check("redir_stall_cycles", bus.stall_cycles,   exp_stall);

        // Load-use with md_start: one stall, then the re-presented md_start issues.
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd3; bus.id_rt = 5'd3; bus.id_use_rt = 1'b1;
        bus.id_md_start = 1'b1;
        #1;
        check("lumd_pc_write", {31'd0, bus.pc_write}, 32'd0);
        check("lumd_md_busy",  {31'd0, bus.md_busy},  32'd0);
        tick();
        bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0;
        #1;
        check("lumd_issue_pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("lumd_issue_md_busy",  {31'd0, bus.md_busy},  32'd0);
        tick();
        set_idle();
        // Second wait cycle carries a redirect: PC moves, wait continues.
        for (int i = 0; i < 4; i++) begin
            bus.ex_redirect = (i == 1);
            #1;
            check($sformatf("lumd_wait%0d_busy", i), {31'd0, bus.md_busy}, 32'd1);
            check($sformatf("lumd_wait%0d_pc_write", i), {31'd0, bus.pc_write},
                  (i == 1) ? 32'd1 : 32'd0);
            check($sformatf("lumd_wait%0d_flush", i), {31'd0, bus.ifid_flush},
                  (i == 1) ? 32'd1 : 32'd0);
            tick();
        end
        set_idle();
        exp_stall = 32'd10;
        #1;
        check("lumd_done_busy",    {31'd0, bus.md_busy}, 32'd0);
        check("lumd_stall_cycles", bus.stall_cycles,     exp_stall);
        tick();

        // Reset pulsed mid-wait (cnt=2).
        bus.id_md_start = 1'b1;
        #1;
        tick();
        bus.id_md_start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_pc_write", {31'd0, bus.pc_write},   32'd0);
        check("midrst_flush",    {31'd0, bus.ifid_flush}, 32'd1);
        check("midrst_md_busy",  {31'd0, bus.md_busy},    32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("postrst_md_busy",  {31'd0, bus.md_busy},     32'd0);
        check("postrst_stall",    bus.stall_cycles,         32'd0);
        check("postrst_pc_write", {31'd0, bus.pc_write},    32'd1);
        check("postrst_bubble",   {31'd0, bus.idex_bubble}, 32'd0);
        tick();
        check("postrst2_pc_write", {31'd0, bus.pc_write}, 32'd1);
        check("postrst2_stall",    bus.stall_cycles,      32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It sits between the IF/ID and ID/EX pipeline registers and decides, every cycle, whether the PC and IF/ID advance, whether IF/ID is flushed, and whether ID/EX captures the decoded instruction or a bubble with all control fields zeroed. It also runs a multi-cycle mult/div wait state and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MD_LATENCY, 32: cycles the mult/div unit needs after issue; must be ≥ 1.
- CNT_W, 6: width of the mult/div wait counter; must hold MD_LATENCY-1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  Rs field of the instruction in ID.
- id_rt  in  5  Rt field of the instruction in ID.
- id_use_rs  in  1  ID instruction reads Rs.
- id_use_rt  in  1  ID instruction reads Rt.
- id_md_start  in  1  ID instruction is mult/div.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- ex_rt  in  5  Rt (load destination) held in ID/EX.
- ex_redirect  in  1  jump or taken branch resolved in EX this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID capture enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads zeroed control (RegWr, Jump, Condition, ALU_op all 0).
- md_busy  out  1  controller is in MD_WAIT.
- stall_cycles  out  32  count of cycles with pc_write=0 outside reset.

## Operation
- States: RUN, MD_WAIT. Wait counter cnt (CNT_W bits).
- load_use = ex_mem_read & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).
- Priority in RUN, highest first:
  - ex_redirect: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; stay in RUN; load_use and id_md_start are ignored (the ID instruction is squashed).
  - load_use: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0; stay in RUN. id_md_start is ignored this cycle and is re-presented next cycle.
  - id_md_start: normal advance (pc_write=1, ifid_write=1, idex_bubble=0); next state MD_WAIT, cnt ← MD_LATENCY-1.
  - otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- MD_WAIT:
  - pc_write=0, ifid_write=0, idex_bubble=1, md_busy=1.
  - If cnt==0, next state RUN; else cnt ← cnt-1.
  - ex_redirect in MD_WAIT asserts ifid_flush=1 and pc_write=1 for that cycle; the wait is not cancelled.
- stall_cycles increments when pc_write==0 and rst==0; it saturates at 32'hFFFF_FFFF.

## Timing
- Outputs are combinational from state, cnt and inputs. They are valid within the same cycle for the next capture edge of PC, IF/ID and ID/EX.
- A load-use stall lasts exactly 1 cycle; the hazard clears once the load leaves ID/EX.
- Mult/div issue to first unstalled cycle takes MD_LATENCY cycles of MD_WAIT. With MD_LATENCY=1 there is exactly one stall cycle.
- Reset, applied while rst is high and on the first edge:
  - state=RUN, cnt=0, stall_cycles=0.
  - Outputs forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, md_busy=0.
- Reset asserted mid-MD_WAIT returns to RUN on the next edge.
- ex_rt==0 never causes a stall.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum: RUN=1'b0, MD_WAIT=1'b1;
  - REG_ZERO=5'd0;
  - the MD_LATENCY default.
- One sub-module, hazard_cmp: a purely combinational load_use comparator, reused later for forwarding-unit compares.

## Test plan
- Load to $5 in ID/EX, ID instruction reads id_rs=5 (id_use_rs=1):
  - one cycle with pc_write=0, ifid_write=0, idex_bubble=1;
  - next cycle all advance;
  - stall_cycles=1.
- Load with ex_rt=0 and id_rs=0 -> no stall.
- id_md_start with MD_LATENCY=4 -> md_busy high for exactly 4 cycles with pc_write=0, then RUN; stall_cycles=4.
- ex_redirect and load_use in the same cycle -> ifid_flush=1, idex_bubble=1, pc_write=1, no stall.
- load_use and id_md_start in the same cycle -> 1 stall cycle, then MD_WAIT begins on the following cycle.
- rst pulsed during MD_WAIT with cnt=2 -> next cycle md_busy=0, stall_cycles=0, and normal advance after rst drops.
